// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART transmit-side blocks.
//   DATA_WD      - default byte width, shared with uart_tx.
//   sch_state_t  - one-hot state encoding of the uart_tx_sched FSM.
//   rr_wrap      - folds an index in [0, 2*n) back into [0, n).
package uart_pkg;

  localparam int unsigned DATA_WD = 8;

  typedef enum logic [4:0] {
    SCH_IDLE      = 5'b00001,
    SCH_GRANT     = 5'b00010,
    SCH_START     = 5'b00100,
    SCH_WAIT_DONE = 5'b01000,
    SCH_RELEASE   = 5'b10000
  } sch_state_t;

  function automatic int unsigned rr_wrap(input int unsigned idx, input int unsigned n);
    return (idx >= n) ? idx - n : idx;
  endfunction

endpackage

// File: rtl/uart_tx_sched_rr_arbiter.sv
// rr_arbiter: combinational round-robin priority search.
//   req       - request vector.
//   rr_ptr    - index where the search starts (wraps upward).
//   grant     - one-hot winner (zero when nothing is requested).
//   grant_idx - index of the winner.
//   any       - at least one request is set.
module rr_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned N_REQ = 4
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] rr_ptr,
  output logic [N_REQ-1:0]         grant,
  output logic [$clog2(N_REQ)-1:0] grant_idx,
  output logic                     any
);

  localparam int unsigned IDW = $clog2(N_REQ);

  int unsigned idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    idx       = 0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      idx = rr_wrap(32'(rr_ptr) + i, N_REQ);
      if (!any && req[IDW'(idx)]) begin
        any                = 1'b1;
        grant[IDW'(idx)]   = 1'b1;
        grant_idx          = IDW'(idx);
      end
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// uart_tx_sched: round-robin scheduler sharing one uart_tx among N_REQ
// byte producers.
//   clk, rst     - clock; asynchronous active-high reset.
//   req          - level request per requester, held until its gnt.
//   req_data     - byte of requester i at [i*data_wd +: data_wd].
//   gnt          - one-cycle one-hot pulse: byte captured.
//   tx_start     - start strobe to the transmitter.
//   tx_din       - byte to the transmitter, stable for the whole frame.
//   tx_busy      - busy flag from the transmitter.
//   frame_done   - one-cycle pulse on frame completion (tx_busy fall).
//   cur_id       - requester currently being served.
//   sched_busy   - high outside IDLE.
//   err_timeout  - sticky: transmitter never started within START_TIMEOUT.
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int unsigned N_REQ         = 4,
  parameter int unsigned data_wd       = DATA_WD,
  parameter int unsigned START_TIMEOUT = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ*data_wd-1:0]   req_data,
  output logic [N_REQ-1:0]           gnt,
  output logic                       tx_start,
  output logic [data_wd-1:0]         tx_din,
  input  logic                       tx_busy,
  output logic                       frame_done,
  output logic [$clog2(N_REQ)-1:0]   cur_id,
  output logic                       sched_busy,
  output logic                       err_timeout
);

  localparam int unsigned IDW = $clog2(N_REQ);
  localparam int unsigned CW  = $clog2(START_TIMEOUT);
  localparam logic [CW-1:0]  CNT_LAST = CW'(START_TIMEOUT - 1);
  localparam logic [IDW-1:0] ID_LAST  = IDW'(N_REQ - 1);

  sch_state_t       state_q, state_d;
  logic [IDW-1:0]   rr_ptr_q;
  logic [CW-1:0]    cnt_q;
  logic             busy_prev_q;
  logic [N_REQ-1:0] req_snap_q;

  logic [N_REQ-1:0] win_grant;
  logic [IDW-1:0]   win_idx;
  logic             win_any;
  logic [IDW-1:0]   next_ptr;

  logic do_grant;
  logic cnt_inc;
  logic set_err;
  logic done_pulse;

  // Arbitration runs on the request vector seen in the last IDLE cycle, so a
  // requester dropping req during GRANT still has its capture completed.
  rr_arbiter #(
    .N_REQ (N_REQ)
  ) u_arb (
    .req       (req_snap_q),
    .rr_ptr    (rr_ptr_q),
    .grant     (win_grant),
    .grant_idx (win_idx),
    .any       (win_any)
  );

  assign next_ptr = (win_idx == ID_LAST) ? '0 : win_idx + IDW'(1);

  always_comb begin
    state_d    = state_q;
    do_grant   = 1'b0;
    cnt_inc    = 1'b0;
    set_err    = 1'b0;
    done_pulse = 1'b0;
    case (state_q)
      SCH_IDLE: begin
        if (|req) state_d = SCH_GRANT;
      end
      SCH_GRANT: begin
        do_grant = win_any;
        state_d  = win_any ? SCH_START : SCH_RELEASE;
      end
      SCH_START: begin
        if (tx_busy) begin
          state_d = SCH_WAIT_DONE;
        end else if (cnt_q == CNT_LAST) begin
          set_err = 1'b1;
          state_d = SCH_RELEASE;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      SCH_WAIT_DONE: begin
        if (busy_prev_q && !tx_busy) begin
          done_pulse = 1'b1;
          state_d    = SCH_RELEASE;
        end
      end
      SCH_RELEASE: begin
        state_d = SCH_IDLE;
      end
      default: begin
        state_d = SCH_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= SCH_IDLE;
      rr_ptr_q    <= '0;
      cnt_q       <= '0;
      busy_prev_q <= 1'b0;
      req_snap_q  <= '0;
      gnt         <= '0;
      tx_din      <= '0;
      frame_done  <= 1'b0;
      cur_id      <= '0;
      err_timeout <= 1'b0;
    end else begin
      state_q     <= state_d;
      busy_prev_q <= tx_busy;
      gnt         <= '0;
      frame_done  <= done_pulse;
      if (state_q == SCH_IDLE) req_snap_q <= req;
      if (do_grant) begin
        gnt      <= win_grant;
        cur_id   <= win_idx;
        tx_din   <= req_data[win_idx*data_wd +: data_wd];
        rr_ptr_q <= next_ptr;
        cnt_q    <= '0;
      end else if (cnt_inc) begin
        cnt_q <= cnt_q + CW'(1);
      end
      if (set_err) err_timeout <= 1'b1;
    end
  end

  assign tx_start   = (state_q == SCH_START);
  assign sched_busy = (state_q != SCH_IDLE);

endmodule

// File: doc/uart_tx_sched.md
# uart_tx_sched

Round-robin scheduler that shares one `uart_tx` transmitter among `N_REQ` byte producers (e.g. debug, status, command-response channels). Each requester presents a byte with a level request. The scheduler grants one requester at a time and drives the transmitter's `tx_start`/`din`. It holds `din` stable for the whole frame, detects frame completion, and aborts with an error flag if the transmitter never starts. It sits between the producer blocks and the single `uart_tx` instance.

## Interface

**Parameters**
- `N_REQ`, 4 — number of requesters (2..8).
- `data_wd`, 8 — byte width; must match the transmitter.
- `START_TIMEOUT`, 64 — clk cycles allowed for `tx_busy` to rise after `tx_start` is asserted.

**Ports**
- `clk` input 1 — system clock.
- `rst` input 1 — reset, asynchronous, active-high.
- `req` input N_REQ — level request per requester; held until its `gnt` pulse.
- `req_data` input N_REQ*data_wd — byte for requester i at bits [i*data_wd +: data_wd].
- `gnt` output N_REQ — one-cycle one-hot pulse; the byte was captured, and the requester may drop `req` or change data.
- `tx_start` output 1 — to the transmitter.
- `tx_din` output data_wd — to the transmitter's `din`; stable from capture until the frame completes.
- `tx_busy` input 1 — from the transmitter.
- `frame_done` output 1 — one-cycle pulse when a frame completes.
- `cur_id` output $clog2(N_REQ) — index of the requester currently being served.
- `sched_busy` output 1 — high in every state except IDLE.
- `err_timeout` output 1 — sticky; set on a start timeout and cleared only by `rst`.

## Operation

- One-hot FSM with states IDLE, GRANT, START, WAIT_DONE, RELEASE.
- **IDLE**
  - If `|req`: go to GRANT.
- **GRANT** (1 cycle)
  - Round-robin pick: the first set `req` bit at or after `rr_ptr`, searching upward and wrapping.
  - Register the winner into `cur_id`.
  - Capture `req_data[winner]` into `tx_din`.
  - Pulse `gnt[winner]`.
  - Set `rr_ptr` = winner+1 mod N_REQ.
  - Go to START.
- **START**
  - `tx_start`=1 and the timeout counter increments.
  - If `tx_busy`=1: drop `tx_start` and go to WAIT_DONE.
  - Else if the counter reaches START_TIMEOUT-1: drop `tx_start`, set `err_timeout`, and go to RELEASE without pulsing `frame_done`.
- **WAIT_DONE**
  - Hold `tx_din`.
  - On `tx_busy` 1→0 (registered previous value is 1, current is 0): pulse `frame_done` and go to RELEASE.
- **RELEASE** (1 cycle)
  - Guard cycle with `tx_start`=0 so the transmitter returns to its idle state.
  - Then go to IDLE.
- If `req` drops during GRANT, the capture still completes; the requester is responsible for holding `req`.
- A requester that drops `req` before being granted is simply skipped.
- A requester re-raising `req` immediately after `gnt` is served again only after all other pending requesters (fairness).
- `tx_done` from the transmitter is sticky and is not used. Completion is defined solely by the `tx_busy` falling edge.

## Timing

- **Reset values**
  - State IDLE; `gnt`=0, `tx_start`=0, `tx_din`=0, `frame_done`=0, `cur_id`=0, `sched_busy`=0, `err_timeout`=0.
  - `rr_ptr`=0, timeout counter=0.
- **Request to start latency**
  - `req` seen in IDLE at cycle n.
  - GRANT at n+1: `gnt` and capture, registered, visible at n+2.
  - `tx_start` high from n+2 until the cycle after `tx_busy` is sampled high.
- **Completion to next grant**
  - `frame_done` is visible the cycle after the falling edge of `tx_busy` is detected.
  - RELEASE, then IDLE, then GRANT: next `gnt` is at least 3 cycles after `frame_done`.
- **Simultaneous requests**
  - Resolved purely by `rr_ptr`. After reset, requester 0 wins ties.
- **Reset mid-frame**
  - All outputs return to reset values immediately (asynchronous).
  - The in-flight byte is dropped; the requester has already seen `gnt` and must not expect a retry.
- **Timeout counter width** is $clog2(START_TIMEOUT); it clears on entry to START.

## Structure

- **Shared package `uart_pkg`**
  - FSM state encodings (one-hot localparams `SCH_IDLE` … `SCH_RELEASE`).
  - `data_wd` default shared with `uart_tx`.
- **Sub-module `rr_arbiter`** (combinational priority search)
  - Inputs: `req`, `rr_ptr`.
  - Outputs: one-hot `grant`, `grant_idx`, `any`.
  - Reusable for a future RX-side dispatcher.

## Test plan

- **Single request:** `req`=4'b0100, `req_data[23:16]`=8'hA5 → `gnt`=4'b0100 one cycle; `tx_start` high until `tx_busy`; `tx_din`=8'hA5 through the frame; one `frame_done`; `cur_id`=2.
- **Fairness:** `req`=4'b1111 held for 8 frames → grant order 0,1,2,3,0,1,2,3 with no repeats.
- **Timeout:** `tx_busy` tied 0, `req`=4'b0001 → `tx_start` high exactly 64 cycles; `err_timeout`=1 and sticky; no `frame_done`; back to IDLE.
- **Back-to-back:** requester 1 re-raises `req` the cycle after `gnt` while requester 3 is pending → requester 3 is served before requester 1.
- **Reset mid-frame:** `rst` asserted in WAIT_DONE → all outputs at reset values the same cycle; after release, `req`=4'b0010 → granted with `rr_ptr` restarting at 0.
- **Real transmitter:** with `uart_tx` instantiated, 3 bytes 8'h55, 8'h00, 8'hFF from different requesters → decoded serial line matches in grant order.
